// File: rtl/mul_result_collector_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_result_collector_if
//  Brief    : Bus bundle between the operand source / multiplier outputs /
//             result consumer and the multiplier result collector.
//  Revision : 1.0 - initial release
// ============================================================================
interface mul_result_collector_if #(
    parameter int DEPTH = 4
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    // Issue side
    logic               issue_valid;
    logic               issue_ready;

    // Raw multiplier outputs (no valid signalling of their own)
    logic [22:0]        Mz;
    logic [7:0]         Ez;
    logic               Sz;
    logic               invalid_flagex;
    logic               overflow_flagex;
    logic               underflow_flagex;
    logic               inexact_flagex;
    logic               zero_flagex;

    // Result stream
    logic               res_valid;
    logic               res_ready;
    logic [31:0]        res_data;
    logic [4:0]         res_flags;

    // Status
    logic [c_CNT_W-1:0] outstanding;
    logic               drop_err;

    // Environment side: operand source, multiplier and result consumer
    modport master (
        output issue_valid,
        input  issue_ready,
        output Mz, Ez, Sz,
        output invalid_flagex, overflow_flagex, underflow_flagex,
        output inexact_flagex, zero_flagex,
        input  res_valid,
        output res_ready,
        input  res_data, res_flags,
        input  outstanding, drop_err
    );

    // Collector side
    modport slave (
        input  issue_valid,
        output issue_ready,
        input  Mz, Ez, Sz,
        input  invalid_flagex, overflow_flagex, underflow_flagex,
        input  inexact_flagex, zero_flagex,
        output res_valid,
        input  res_ready,
        output res_data, res_flags,
        output outstanding, drop_err
    );
endinterface

`default_nettype wire

// File: rtl/mul_result_collector.sv
`default_nettype none
// ============================================================================
//  Module   : mul_result_collector
//  Brief    : Tracks operations through a fixed-latency multiplier with a
//             token pipe, captures the emerging results into a FWFT FIFO and
//             hands out issue credits so no result can ever be lost.
//  Revision : 1.0 - initial release
// ============================================================================
module mul_result_collector #(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    mul_result_collector_if.slave bus
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

    logic                w_ready;
    logic                w_fire;
    logic                w_valid;
    logic                w_pop;
    logic                w_arrive;

    logic [LATENCY-1:0]  r_token;
    logic [31:0]         r_data_mem [DEPTH];
    logic [4:0]          r_flag_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  r_outstanding;
    logic                r_drop_err;

    // Credits come straight from the registered counter, so issue_ready
    // has no combinational path from any input.
    assign w_ready  = (r_outstanding < c_DEPTH_CNT);
    assign w_fire   = bus.issue_valid & w_ready;
    assign w_valid  = (r_count != '0);
    assign w_pop    = w_valid & bus.res_ready;
    assign w_arrive = r_token[LATENCY-1];

    // Token pipe: one bit per multiplier stage, last stage marks a valid result
    generate
        if (LATENCY == 1) begin : g_pipe_single
            always_ff @(posedge CLK) begin
                if (RST) r_token <= '0;
                else     r_token <= w_fire;
            end
        end else begin : g_pipe_shift
            always_ff @(posedge CLK) begin
                if (RST) r_token <= '0;
                else     r_token <= {r_token[LATENCY-2:0], w_fire};
            end
        end
    endgenerate

    // Result storage: multiplier outputs sampled directly on the arrive edge
    always_ff @(posedge CLK) begin
        if (w_arrive) begin
            r_data_mem[r_wr_ptr] <= {bus.Sz, bus.Ez, bus.Mz};
            r_flag_mem[r_wr_ptr] <= {bus.invalid_flagex, bus.overflow_flagex,
                                     bus.underflow_flagex, bus.inexact_flagex,
                                     bus.zero_flagex};
        end
    end

    // FIFO pointers and occupancy; credits guarantee no push into a full FIFO
    // unless a pop happens on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_arrive) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_arrive, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Outstanding = tokens in flight + buffered results
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_outstanding <= '0;
        end else begin
            case ({w_fire, w_pop})
                2'b10:   r_outstanding <= r_outstanding + c_CNT_ONE;
                2'b01:   r_outstanding <= r_outstanding - c_CNT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Sticky flag for an issue attempted without a credit
    always_ff @(posedge CLK) begin
        if (RST)                                r_drop_err <= 1'b0;
        else if (bus.issue_valid && !w_ready)   r_drop_err <= 1'b1;
    end

    assign bus.issue_ready = w_ready;
    assign bus.res_valid   = w_valid;
    assign bus.res_data    = w_valid ? r_data_mem[r_rd_ptr] : 32'h0;
    assign bus.res_flags   = w_valid ? r_flag_mem[r_rd_ptr] : 5'h0;
    assign bus.outstanding = r_outstanding;
    assign bus.drop_err    = r_drop_err;

endmodule

`default_nettype wire
